// File: rtl/up_bus_initiator_pkg.sv
// Shared definitions for the up register bus initiator and its timer.
//   state_t            : FSM state encoding (IDLE/REQ/WAIT/RESP)
//   timer_width()      : counter width needed for a given ack window
//   RSP_OK/RSP_ERR_*   : values carried on rsp_error
//   TIMEOUT_COUNT_MAX  : saturation value of the timeout statistics counter
package up_bus_initiator_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  localparam logic RSP_OK          = 1'b0;
  localparam logic RSP_ERR_TIMEOUT = 1'b1;

  localparam logic [15:0] TIMEOUT_COUNT_MAX = 16'hFFFF;

  // The timer counts 0 .. cycles-1, so clog2(cycles) bits are enough;
  // never less than one bit.
  function automatic int timer_width(input int cycles);
    return (cycles <= 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/up_bus_timeout_timer.sv
// Clear/enable/expire counter bounding how long a bus access may wait.
//   clk, reset : clock, synchronous active-high reset
//   clear      : force the count to 0 (takes priority over enable)
//   enable     : advance the count by one (holds at the last value)
//   expire     : high while the count equals TIMEOUT_CYCLES-1, i.e. in the
//                TIMEOUT_CYCLES-th enabled cycle after a clear
module up_bus_timeout_timer
  import up_bus_initiator_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int TW = timer_width(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT_CYCLES - 1);

  logic [TW-1:0] count;

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (enable && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/up_bus_initiator.sv
// Initiator for the internal up register bus. Takes single read/write
// commands, issues one up_wreq/up_rreq pulse, waits for the matching ack
// (bounded by TIMEOUT_CYCLES) and returns one response per command.
//
// Handshakes: a transfer happens on a rising clk edge where valid && ready
// are both high. The producer holds valid and payload stable until that
// edge; the consumer may raise/lower ready freely. cmd_ready is high only
// in IDLE (never during reset); rsp_valid is high only in RESP, where the
// rsp_* payload is frozen until rsp_ready.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   cmd_valid/ready/write/addr/wdata   command stream
//   rsp_valid/ready/write/rdata/error  response stream (error = ack timeout)
//   up_wreq/waddr/wdata, up_wack       write side of the up bus
//   up_rreq/raddr, up_rdata, up_rack   read side of the up bus
//   busy                        high outside IDLE
//   timeout_count               saturating count of timed-out accesses
//   fsm_state                   current FSM state, for observation
module up_bus_initiator
  import up_bus_initiator_pkg::*;
#(
  parameter int ADDRESS_WIDTH  = 14,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     cmd_write,
  input  logic [ADDRESS_WIDTH-1:0] cmd_addr,
  input  logic [31:0]              cmd_wdata,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic                     rsp_write,
  output logic [31:0]              rsp_rdata,
  output logic                     rsp_error,
  output logic                     up_wreq,
  output logic [ADDRESS_WIDTH-1:0] up_waddr,
  output logic [31:0]              up_wdata,
  input  logic                     up_wack,
  output logic                     up_rreq,
  output logic [ADDRESS_WIDTH-1:0] up_raddr,
  input  logic [31:0]              up_rdata,
  input  logic                     up_rack,
  output logic                     busy,
  output logic [15:0]              timeout_count,
  output logic [1:0]               fsm_state
);

  state_t state;
  state_t state_nxt;

  logic lat_write;
  logic accept;
  logic ack_match;
  logic complete;
  logic timed_out;
  logic timer_clear;
  logic timer_en;
  logic timer_expire;

  assign cmd_ready = (state == ST_IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;

  // Only the ack of the access type in flight counts; the other one is noise.
  assign ack_match = lat_write ? up_wack : up_rack;
  assign complete  = (state == ST_WAIT) && ack_match;
  // A matching ack in the last window cycle beats the timeout.
  assign timed_out = (state == ST_WAIT) && !ack_match && timer_expire;

  up_bus_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk    (clk),
    .reset  (reset),
    .clear  (timer_clear),
    .enable (timer_en),
    .expire (timer_expire)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    timer_clear = 1'b0;
    timer_en    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_REQ;
      end
      ST_REQ: begin
        // Acks seen in the pulse cycle itself are ignored.
        timer_clear = 1'b1;
        state_nxt   = ST_WAIT;
      end
      ST_WAIT: begin
        if (complete || timed_out) begin
          state_nxt = ST_RESP;
        end else begin
          timer_en = 1'b1;
        end
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Address/data buses are loaded only for their own access type and then
  // held, so a late-sampling responder still sees the last values.
  always_ff @(posedge clk) begin
    if (reset) begin
      lat_write     <= 1'b0;
      up_waddr      <= '0;
      up_wdata      <= '0;
      up_raddr      <= '0;
      rsp_rdata     <= '0;
      rsp_error     <= 1'b0;
      timeout_count <= '0;
    end else begin
      if (accept) begin
        lat_write <= cmd_write;
        if (cmd_write) begin
          up_waddr <= cmd_addr;
          up_wdata <= cmd_wdata;
        end else begin
          up_raddr <= cmd_addr;
        end
      end
      if (complete) begin
        rsp_rdata <= lat_write ? 32'd0 : up_rdata;
        rsp_error <= RSP_OK;
      end
      if (timed_out) begin
        rsp_rdata <= 32'd0;
        rsp_error <= RSP_ERR_TIMEOUT;
        if (timeout_count != TIMEOUT_COUNT_MAX) begin
          timeout_count <= timeout_count + 16'd1;
        end
      end
    end
  end

  assign up_wreq   = (state == ST_REQ) && lat_write;
  assign up_rreq   = (state == ST_REQ) && !lat_write;
  assign rsp_valid = (state == ST_RESP);
  assign rsp_write = lat_write;
  assign busy      = (state != ST_IDLE);
  assign fsm_state = state;

endmodule

// File: tb/tb_up_bus_initiator.sv
// Bench for up_bus_initiator with a short ack window (TIMEOUT_CYCLES = 8).
// All DUT outputs are sampled and all inputs driven at the falling edge.
module tb_up_bus_initiator;

  localparam int AW = 14;
  localparam int TC = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic          rsp_ready;
  logic          rsp_write;
  logic [31:0]   rsp_rdata;
  logic          rsp_error;
  logic          up_wreq;
  logic [AW-1:0] up_waddr;
  logic [31:0]   up_wdata;
  logic          up_wack;
  logic          up_rreq;
  logic [AW-1:0] up_raddr;
  logic [31:0]   up_rdata;
  logic          up_rack;
  logic          busy;
  logic [15:0]   timeout_count;
  logic [1:0]    fsm_state;

  // directed responder (driven by the access task) and automatic responder
  logic        tw_wack, tw_rack, aw_wack, aw_rack, auto_en;
  logic [31:0] tw_rdata, aw_rdata;
  logic        wreq_d, rreq_d;

  assign up_wack  = tw_wack | aw_wack;
  assign up_rack  = tw_rack | aw_rack;
  assign up_rdata = auto_en ? aw_rdata : tw_rdata;

  up_bus_initiator #(
    .ADDRESS_WIDTH (AW),
    .TIMEOUT_CYCLES(TC)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_write     (cmd_write),
    .cmd_addr      (cmd_addr),
    .cmd_wdata     (cmd_wdata),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_write     (rsp_write),
    .rsp_rdata     (rsp_rdata),
    .rsp_error     (rsp_error),
    .up_wreq       (up_wreq),
    .up_waddr      (up_waddr),
    .up_wdata      (up_wdata),
    .up_wack       (up_wack),
    .up_rreq       (up_rreq),
    .up_raddr      (up_raddr),
    .up_rdata      (up_rdata),
    .up_rack       (up_rack),
    .busy          (busy),
    .timeout_count (timeout_count),
    .fsm_state     (fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // ---------------- reference model state ----------------
  logic [46:0]   exp_q[$];      // expected request pulses {write, addr, wdata}
  int            pulses     = 0;
  int            exp_pulses = 0;
  logic [AW-1:0] m_waddr, m_raddr;
  logic [31:0]   m_wdata;
  int            m_tc;
  logic [46:0]   e;

  // request pulse scoreboard
  always @(negedge clk) begin
    if (up_wreq || up_rreq) begin
      pulses++;
      check("req_one_hot", {63'd0, up_wreq & up_rreq}, 64'd0);
      check("req_pending", {63'd0, exp_q.size() > 0}, 64'd1);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("req_kind", {63'd0, up_wreq}, {63'd0, e[46]});
        check("req_addr", {50'd0, (up_wreq ? up_waddr : up_raddr)}, {50'd0, e[45:32]});
        if (up_wreq) check("req_wdata", {32'd0, up_wdata}, {32'd0, e[31:0]});
      end
    end
  end

  // automatic responder: acks one cycle after each pulse, data derived from address
  always @(negedge clk) begin
    aw_wack  = auto_en && wreq_d;
    aw_rack  = auto_en && rreq_d;
    aw_rdata = 32'hC0DE_0000 ^ {18'd0, up_raddr};
    wreq_d   = up_wreq;
    rreq_d   = up_rreq;
  end

  // ---------------- driver tasks ----------------
  task automatic drive_acks(input int k, input logic wr, input int d,
                            input logic stray, input logic [31:0] rdata);
    int stray_k;
    stray_k  = (d == 1) ? 2 : 1;
    tw_wack  = (wr && k == d) || (!wr && stray && k == stray_k);
    tw_rack  = (!wr && k == d) || (wr && stray && k == stray_k);
    tw_rdata = (k == d) ? rdata : $urandom;
  endtask

  // One access with rsp_ready held low for the whole ack window plus a few
  // cycles. d = cycle offset of the matching ack from the request cycle
  // (0 = in the request cycle, > TC = too late). Entered at a falling edge
  // in IDLE, leaves at a falling edge in IDLE.
  task automatic do_access(input logic wr, input logic [AW-1:0] addr,
                           input logic [31:0] wdata, input logic [31:0] rdata,
                           input int d, input logic stray);
    int   exp_k, seen_k;
    logic ok;
    logic dropped;
    ok      = (d >= 1) && (d <= TC);
    exp_k   = ok ? d + 1 : TC + 1;
    seen_k  = -1;
    dropped = 1'b0;

    check("idle_ready", {63'd0, cmd_ready}, 64'd1);
    cmd_valid = 1'b1;
    cmd_write = wr;
    cmd_addr  = addr;
    cmd_wdata = wdata;
    exp_q.push_back({wr, addr, wdata});
    exp_pulses++;

    @(negedge clk);                     // request cycle
    cmd_valid = 1'b0;
    cmd_write = 1'($urandom);
    cmd_addr  = AW'($urandom);
    cmd_wdata = $urandom;
    if (wr) begin
      m_waddr = addr;
      m_wdata = wdata;
    end else begin
      m_raddr = addr;
    end
    check("bus_waddr", {50'd0, up_waddr}, {50'd0, m_waddr});
    check("bus_wdata", {32'd0, up_wdata}, {32'd0, m_wdata});
    check("bus_raddr", {50'd0, up_raddr}, {50'd0, m_raddr});
    check("req_not_ready", {63'd0, cmd_ready}, 64'd0);
    drive_acks(0, wr, d, stray, rdata);

    for (int k = 1; k <= TC + 6; k++) begin
      @(negedge clk);
      if (rsp_valid && seen_k < 0) seen_k = k;
      if (seen_k >= 0 && !rsp_valid) dropped = 1'b1;
      drive_acks(k, wr, d, stray, rdata);
    end
    tw_wack = 1'b0;
    tw_rack = 1'b0;

    if (!ok) m_tc++;
    check("rsp_latency", 64'(seen_k), 64'(exp_k));
    check("rsp_dropped", {63'd0, dropped}, 64'd0);
    check("rsp_held", {63'd0, rsp_valid}, 64'd1);
    check("rsp_write", {63'd0, rsp_write}, {63'd0, wr});
    check("rsp_rdata", {32'd0, rsp_rdata}, {32'd0, (ok && !wr) ? rdata : 32'd0});
    check("rsp_error", {63'd0, rsp_error}, {63'd0, !ok});
    check("timeout_count", {48'd0, timeout_count}, 64'(m_tc));
    check("resp_not_ready", {63'd0, cmd_ready}, 64'd0);

    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("after_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("after_rsp_busy", {63'd0, busy}, 64'd0);
    check("after_rsp_ready", {63'd0, cmd_ready}, 64'd1);
    check("hold_waddr", {50'd0, up_waddr}, {50'd0, m_waddr});
    check("hold_raddr", {50'd0, up_raddr}, {50'd0, m_raddr});
    check("pulse_count", 64'(pulses), 64'(exp_pulses));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_cmd_ready"}, {63'd0, cmd_ready}, 64'd0);
    check({tag, "_rsp"}, {30'd0, rsp_valid, rsp_write, rsp_rdata}, 64'd0);
    check({tag, "_rsp_error"}, {63'd0, rsp_error}, 64'd0);
    check({tag, "_req"}, {62'd0, up_wreq, up_rreq}, 64'd0);
    check({tag, "_addr"}, {36'd0, up_waddr, up_raddr}, 64'd0);
    check({tag, "_wdata"}, {32'd0, up_wdata}, 64'd0);
    check({tag, "_busy_tc"}, {47'd0, busy, timeout_count}, 64'd0);
  endtask

  // ---------------- sequence ----------------
  initial begin
    logic          twr[4];
    logic [AW-1:0] tad[4];
    logic [31:0]   twd[4];
    logic [32:0]   rsp_q[$];
    logic [32:0]   r;
    int            acc_cyc[4];
    int            n_acc, rsp_n;
    logic          just_acc;

    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_write = 1'b0;
    cmd_addr  = '0;
    cmd_wdata = '0;
    rsp_ready = 1'b0;
    tw_wack   = 1'b0;
    tw_rack   = 1'b0;
    tw_rdata  = '0;
    auto_en   = 1'b0;
    aw_wack   = 1'b0;
    aw_rack   = 1'b0;
    aw_rdata  = '0;
    wreq_d    = 1'b0;
    rreq_d    = 1'b0;
    m_waddr   = '0;
    m_wdata   = '0;
    m_raddr   = '0;
    m_tc      = 0;

    repeat (3) @(negedge clk);
    check_all_zero("reset");
    reset = 1'b0;
    @(negedge clk);
    check("post_reset_ready", {63'd0, cmd_ready}, 64'd1);

    // reset in the middle of a read; the ack that follows must be ignored
    cmd_valid = 1'b1;
    cmd_write = 1'b0;
    cmd_addr  = 14'h0055;
    exp_q.push_back({1'b0, 14'h0055, 32'd0});
    exp_pulses++;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    check("mid_busy", {63'd0, busy}, 64'd1);
    reset = 1'b1;
    @(negedge clk);
    check_all_zero("mid_reset");
    reset    = 1'b0;
    tw_rack  = 1'b1;
    tw_rdata = 32'hFFFF_0000;
    m_raddr  = '0;
    @(negedge clk);
    tw_rack = 1'b0;
    begin
      logic seen;
      seen = 1'b0;
      for (int k = 0; k < 12; k++) begin
        if (rsp_valid || busy) seen = 1'b1;
        @(negedge clk);
      end
      check("mid_reset_no_rsp", {63'd0, seen}, 64'd0);
    end
    check("mid_reset_tc", {48'd0, timeout_count}, 64'd0);
    check("mid_reset_pulses", 64'(pulses), 64'(exp_pulses));

    // directed accesses
    do_access(1'b1, 14'h0040, 32'hA5A5_0001, 32'd0,        2,      1'b0);
    do_access(1'b0, 14'h0041, 32'd0,         32'h1234_5678, 1,      1'b0);
    do_access(1'b0, 14'h2ABC, 32'd0,         32'hDEAD_BEEF, TC + 4, 1'b0);
    do_access(1'b0, 14'h0100, 32'd0,         32'h0BAD_F00D, TC,     1'b0);
    do_access(1'b0, 14'h0101, 32'd0,         32'h0000_0077, TC + 1, 1'b0);
    do_access(1'b0, 14'h0102, 32'd0,         32'h5555_AAAA, 5,      1'b1);
    do_access(1'b1, 14'h3FFF, 32'hFFFF_FFFF, 32'd0,        0,      1'b1);
    do_access(1'b1, 14'h0000, 32'h0000_0000, 32'd0,        1,      1'b0);

    // randomized accesses
    for (int i = 0; i < 30; i++) begin
      do_access(1'($urandom), AW'($urandom), $urandom, $urandom,
                int'($urandom_range(0, TC + 4)), 1'($urandom_range(0, 3) == 0));
    end

    // back-to-back with rsp_ready constantly high and the automatic responder
    auto_en   = 1'b1;
    rsp_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      twr[i] = 1'(i);
      tad[i] = AW'($urandom);
      twd[i] = $urandom;
    end
    n_acc    = 0;
    rsp_n    = 0;
    just_acc = 1'b0;
    cmd_valid = 1'b1;
    cmd_write = twr[0];
    cmd_addr  = tad[0];
    cmd_wdata = twd[0];
    exp_q.push_back({twr[0], tad[0], twd[0]});
    rsp_q.push_back({twr[0], twr[0] ? 32'd0 : (32'hC0DE_0000 ^ {18'd0, tad[0]})});
    exp_pulses++;
    for (int cyc = 0; cyc < 40 && rsp_n < 4; cyc++) begin
      if (rsp_valid) begin
        check("b2b_rsp_pending", {63'd0, rsp_q.size() > 0}, 64'd1);
        if (rsp_q.size() > 0) begin
          r = rsp_q.pop_front();
          check("b2b_rsp_write", {63'd0, rsp_write}, {63'd0, r[32]});
          check("b2b_rsp_rdata", {32'd0, rsp_rdata}, {32'd0, r[31:0]});
          check("b2b_rsp_error", {63'd0, rsp_error}, 64'd0);
        end
        rsp_n++;
      end
      if (just_acc) begin
        just_acc = 1'b0;
        if (n_acc < 4) begin
          cmd_write = twr[n_acc];
          cmd_addr  = tad[n_acc];
          cmd_wdata = twd[n_acc];
          exp_q.push_back({twr[n_acc], tad[n_acc], twd[n_acc]});
          rsp_q.push_back({twr[n_acc],
                           twr[n_acc] ? 32'd0 : (32'hC0DE_0000 ^ {18'd0, tad[n_acc]})});
          exp_pulses++;
        end else begin
          cmd_valid = 1'b0;
        end
      end else if (cmd_valid && cmd_ready) begin
        acc_cyc[n_acc] = cyc;
        n_acc++;
        just_acc = 1'b1;
      end
      @(negedge clk);
    end
    cmd_valid = 1'b0;
    check("b2b_accepts", 64'(n_acc), 64'd4);
    check("b2b_responses", 64'(rsp_n), 64'd4);
    if (n_acc == 4) begin
      for (int i = 1; i < 4; i++) begin
        check("b2b_period", 64'(acc_cyc[i] - acc_cyc[i-1]), 64'd4);
      end
    end
    repeat (4) @(negedge clk);
    auto_en   = 1'b0;
    rsp_ready = 1'b0;
    check("final_pulses", 64'(pulses), 64'(exp_pulses));
    check("final_req_q_empty", 64'(exp_q.size()), 64'd0);
    check("final_tc", {48'd0, timeout_count}, 64'(m_tc));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
